imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction memory capacity in 32-bit words.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  incoming image byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port reload  input  1  single-cycle request to load a new image.
REQ-008 SHALL have port imem_wr_en  output  1  IMEM write strobe.
REQ-009 SHALL have port imem_wr_addr  output  32  word-aligned IMEM byte address.
REQ-010 SHALL have port imem_wr_data  output  32  instruction word to write.
REQ-011 SHALL have port core_reset_n  output  1  active-low core reset; low while loading.
REQ-012 SHALL have port load_done  output  1  image fully written.
REQ-013 SHALL have port load_error  output  1  header word count exceeded DEPTH.

Function
REQ-014 SHALL implement states IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERROR.
REQ-015 SHALL move IDLE->HDR0 unconditionally on the first clock after Reset deasserts.
REQ-016 SHALL drive rx_ready=1 only in HDR0, HDR1, DATA; a byte is accepted when rx_valid && rx_ready.
REQ-017 SHALL capture the accepted byte in HDR0 as N[7:0] and in HDR1 as N[15:8] (N = 16-bit little-endian word count).
REQ-018 SHALL, on HDR1 acceptance, go to DONE if N==0, ERROR if N>DEPTH, else DATA with word index and byte lane cleared to 0.
REQ-019 SHALL, in DATA, place accepted byte at lane L into word bits [8L+7:8L] (little-endian) and increment L mod 4.
REQ-020 SHALL, on acceptance of lane 3, go to WRITE; imem_wr_en SHALL be 1 for exactly that one WRITE cycle, with imem_wr_addr = index*4 and imem_wr_data the assembled word.
REQ-021 SHALL, leaving WRITE, increment index and go to DONE if index+1==N, else DATA.
REQ-022 SHALL hold state and partial word unchanged while rx_valid=0 (gaps of any length allowed).
REQ-023 SHALL drive core_reset_n=1 and load_done=1 only in DONE; 0 in all other states.
REQ-024 SHALL drive load_error=1 only in ERROR; ERROR SHALL be exit-only by Reset, ignoring rx_valid and reload.
REQ-025 SHALL, on reload=1 in DONE, go to HDR0 the next cycle (core_reset_n low that cycle); reload SHALL be ignored in all other states.
REQ-026 SHALL keep imem_wr_en=0 outside WRITE; imem_wr_addr/imem_wr_data are don't-care when imem_wr_en=0.
REQ-027 SHALL never write at address >= DEPTH*4.

Reset
REQ-028 SHALL, while Reset=1, immediately force state IDLE, rx_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, core_reset_n=0, load_done=0, load_error=0, N=0, index=0, lane=0.
REQ-029 SHALL abandon any partial header or word on Reset mid-operation; the next image restarts at address 0.

Verification
REQ-030 SHALL verify single word: bytes 01 00 93 02 50 00 -> one write, addr 0x0, data 0x00500293; next cycle load_done=1, core_reset_n=1.
REQ-031 SHALL verify empty image: bytes 00 00 -> DONE with no imem_wr_en pulse.
REQ-032 SHALL verify overflow: header N=DEPTH+1 (01 04 for 1024) -> load_error=1, rx_ready=0, core_reset_n=0, stays until Reset.
REQ-033 SHALL verify stalls: N=3 with random rx_valid gaps -> writes at 0x0, 0x4, 0x8 with correct data, each imem_wr_en one cycle wide.
REQ-034 SHALL verify Reset asserted after 2 data bytes -> all outputs reset asynchronously; subsequent 01 00 + 4 bytes writes addr 0x0.
REQ-035 SHALL verify reload: in DONE pulse reload -> core_reset_n=0 next cycle; second image overwrites from addr 0x0 and returns to DONE.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a 16-bit little-endian word count
// followed by little-endian instruction bytes, writes them to IMEM and then releases the core.
module imem_loader #(
    parameter int DEPTH = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        core_reset_n,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] n_reg;
    logic [15:0] index_reg;
    logic [1:0]  lane_reg;
    logic [23:0] word_reg;      // lanes 0..2; lane 3 goes straight into the write word
    logic        rx_ready_reg;
    logic        wr_en_reg;
    logic [31:0] wr_addr_reg;
    logic [31:0] wr_data_reg;
    logic        core_reset_n_reg;
    logic        load_done_reg;
    logic        load_error_reg;

    logic        accept;
    logic [15:0] hdr_count;

    assign accept    = rx_valid && rx_ready_reg;
    assign hdr_count = {rx_data, n_reg[7:0]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  state_next = HDR0;
            HDR0:  if (accept) state_next = HDR1;
            HDR1: begin
                if (accept) begin
                    if (hdr_count == 16'd0)
                        state_next = DONE;
                    else if ({16'd0, hdr_count} > DEPTH_U)
                        state_next = ERROR;
                    else
                        state_next = DATA;
                end
            end
            DATA:  if (accept && lane_reg == 2'd3) state_next = WRITE;
            WRITE: state_next = (index_reg + 16'd1 == n_reg) ? DONE : DATA;
            DONE:  if (reload) state_next = HDR0;
            ERROR: state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are Moore-clean and
    // line up exactly with the state they describe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg        <= IDLE;
            n_reg            <= 16'd0;
            index_reg        <= 16'd0;
            lane_reg         <= 2'd0;
            word_reg         <= 24'd0;
            rx_ready_reg     <= 1'b0;
            wr_en_reg        <= 1'b0;
            wr_addr_reg      <= 32'd0;
            wr_data_reg      <= 32'd0;
            core_reset_n_reg <= 1'b0;
            load_done_reg    <= 1'b0;
            load_error_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rx_ready_reg     <= (state_next == HDR0) || (state_next == HDR1) || (state_next == DATA);
            wr_en_reg        <= (state_next == WRITE);
            core_reset_n_reg <= (state_next == DONE);
            load_done_reg    <= (state_next == DONE);
            load_error_reg   <= (state_next == ERROR);

            case (state_reg)
                HDR0: if (accept) n_reg[7:0] <= rx_data;
                HDR1: begin
                    if (accept) begin
                        n_reg[15:8] <= rx_data;
                        index_reg   <= 16'd0;
                        lane_reg    <= 2'd0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        lane_reg <= lane_reg + 2'd1;
                        case (lane_reg)
                            2'd0: word_reg[7:0]   <= rx_data;
                            2'd1: word_reg[15:8]  <= rx_data;
                            2'd2: word_reg[23:16] <= rx_data;
                            default: begin
                                wr_data_reg <= {rx_data, word_reg};
                                wr_addr_reg <= {14'd0, index_reg, 2'b00};
                            end
                        endcase
                    end
                end
                WRITE: index_reg <= index_reg + 16'd1;
                default: ;
            endcase
        end
    end

    assign rx_ready     = rx_ready_reg;
    assign imem_wr_en   = wr_en_reg;
    assign imem_wr_addr = wr_addr_reg;
    assign imem_wr_data = wr_data_reg;
    assign core_reset_n = core_reset_n_reg;
    assign load_done    = load_done_reg;
    assign load_error   = load_error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single/empty/overflow images, stalls, async reset and reload.
module tb_imem_loader;

    localparam int DEPTH = 1024;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        reload = 1'b0;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        core_reset_n;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;

    logic [63:0] wq[$];
    logic        prev_wr_en = 1'b0;
    int          wide_pulses = 0;
    int          bad_addrs = 0;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp;
    } vec_t;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .core_reset_n (core_reset_n),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 Clk = ~Clk;

    // Write monitor: records every strobe and flags strobes wider than one cycle.
    always @(negedge Clk) begin
        if (imem_wr_en) begin
            wq.push_back({imem_wr_addr, imem_wr_data});
            $display("write addr=0x%08h data=0x%08h", imem_wr_addr, imem_wr_data);
            if (prev_wr_en) wide_pulses++;
            if (imem_wr_addr >= 32'(DEPTH * 4)) bad_addrs++;
        end
        prev_wr_en = imem_wr_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 200) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 200) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge Clk);
        reload = 1'b0;
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    vec_t        tbl[4];
    logic [7:0]  stall_bytes[12];
    logic [31:0] stall_words[3];
    logic [63:0] e;

    initial begin
        tbl[0] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp: 32'h00000000};
        tbl[1] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF, exp: 32'hFFFFFFFF};
        tbl[2] = '{b0: 8'h13, b1: 8'h05, b2: 8'hA0, b3: 8'hFF, exp: 32'hFFA00513};
        tbl[3] = '{b0: 8'hB7, b1: 8'h12, b2: 8'h34, b3: 8'h80, exp: 32'h803412B7};
        stall_bytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hF0, 8'hA5, 8'h00, 8'h00};
        stall_words = '{32'h11223344, 32'hDEADBEEF, 32'h0000A5F0};

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
        chk("rst_wr_addr", imem_wr_addr, 32'd0);
        chk("rst_wr_data", imem_wr_data, 32'd0);
        chk("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("hdr0_rx_ready", 32'(rx_ready), 32'd1);
        chk("hdr0_core_reset_n", 32'(core_reset_n), 32'd0);

        // Single word image
        wq.delete();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h02); send_byte(8'h50); send_byte(8'h00);
        chk("single_wr_en", 32'(imem_wr_en), 32'd1);
        chk("single_addr", imem_wr_addr, 32'h0);
        chk("single_data", imem_wr_data, 32'h00500293);
        chk("single_rx_ready_in_write", 32'(rx_ready), 32'd0);
        @(negedge Clk);
        chk("single_load_done", 32'(load_done), 32'd1);
        chk("single_core_reset_n", 32'(core_reset_n), 32'd1);
        chk("single_wr_en_low", 32'(imem_wr_en), 32'd0);
        chk("single_nwrites", 32'(wq.size()), 32'd1);
        $display("txn single_word done");

        // Table of single-word images loaded through reload
        for (int i = 0; i < 4; i++) begin
            wq.delete();
            pulse_reload();
            chk("reload_core_reset_n", 32'(core_reset_n), 32'd0);
            chk("reload_rx_ready", 32'(rx_ready), 32'd1);
            chk("reload_load_done", 32'(load_done), 32'd0);
            send_byte(8'h01); send_byte(8'h00);
            send_byte(tbl[i].b0); send_byte(tbl[i].b1); send_byte(tbl[i].b2); send_byte(tbl[i].b3);
            chk("tbl_wr_en", 32'(imem_wr_en), 32'd1);
            chk("tbl_addr", imem_wr_addr, 32'h0);
            chk("tbl_data", imem_wr_data, tbl[i].exp);
            @(negedge Clk);
            chk("tbl_load_done", 32'(load_done), 32'd1);
            chk("tbl_nwrites", 32'(wq.size()), 32'd1);
            $display("txn table[%0d] exp=0x%08h got=0x%08h", i, tbl[i].exp, imem_wr_data);
        end

        // Empty image
        wq.delete();
        pulse_reload();
        send_byte(8'h00); send_byte(8'h00);
        chk("empty_load_done", 32'(load_done), 32'd1);
        chk("empty_core_reset_n", 32'(core_reset_n), 32'd1);
        repeat (2) @(negedge Clk);
        chk("empty_nwrites", 32'(wq.size()), 32'd0);
        $display("txn empty_image done");

        // Three words with random valid gaps
        wq.delete();
        wide_pulses = 0;
        pulse_reload();
        send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            send_byte(stall_bytes[i]);
        end
        chk("stall_last_wr_en", 32'(imem_wr_en), 32'd1);
        @(negedge Clk);
        chk("stall_load_done", 32'(load_done), 32'd1);
        chk("stall_nwrites", 32'(wq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wq.size()) begin
                e = wq[i];
                chk("stall_addr", e[63:32], 32'(i * 4));
                chk("stall_data", e[31:0], stall_words[i]);
                $display("txn stall word %0d addr=0x%08h data=0x%08h", i, e[63:32], e[31:0]);
            end
        end
        chk("stall_pulse_width", 32'(wide_pulses), 32'd0);

        // Reset in the middle of a word
        wq.delete();
        pulse_reload();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h5A); send_byte(8'h6B);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
        chk("midrst_wr_en", 32'(imem_wr_en), 32'd0);
        chk("midrst_wr_addr", imem_wr_addr, 32'd0);
        chk("midrst_wr_data", imem_wr_data, 32'd0);
        chk("midrst_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("midrst_load_done", 32'(load_done), 32'd0);
        chk("midrst_load_error", 32'(load_error), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        chk("postrst_wr_en", 32'(imem_wr_en), 32'd1);
        chk("postrst_addr", imem_wr_addr, 32'h0);
        chk("postrst_data", imem_wr_data, 32'hDDCCBBAA);
        @(negedge Clk);
        chk("postrst_load_done", 32'(load_done), 32'd1);
        chk("postrst_nwrites", 32'(wq.size()), 32'd1);
        $display("txn reset_mid_word done");

        // Overflow header: DEPTH+1
        wq.delete();
        do_reset();
        send_byte(8'h01); send_byte(8'h04);
        chk("ovf_load_error", 32'(load_error), 32'd1);
        chk("ovf_rx_ready", 32'(rx_ready), 32'd0);
        chk("ovf_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("ovf_load_done", 32'(load_done), 32'd0);
        pulse_reload();
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        repeat (5) @(negedge Clk);
        rx_valid = 1'b0;
        chk("ovf_sticky_error", 32'(load_error), 32'd1);
        chk("ovf_sticky_rx_ready", 32'(rx_ready), 32'd0);
        chk("ovf_nwrites", 32'(wq.size()), 32'd0);
        $display("txn overflow done");

        // Boundary: N == DEPTH is accepted
        do_reset();
        send_byte(8'h00); send_byte(8'h04);
        chk("ndepth_load_error", 32'(load_error), 32'd0);
        chk("ndepth_rx_ready", 32'(rx_ready), 32'd1);
        chk("bad_write_addrs", 32'(bad_addrs), 32'd0);
        $display("txn n_equals_depth done");
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
